// File: rtl/lcd_cmd_host.sv
// Host side of the LCD controller link: image ROM server, command
// sequencer with busy handshake, and IRAM write-back capture.
module lcd_cmd_host #(
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_we,
  input  logic [5:0]  img_addr,
  input  logic [7:0]  img_data,
  input  logic [3:0]  prog_cmd,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic        start,
  input  logic        IROM_rd,
  input  logic [5:0]  IROM_A,
  output logic [7:0]  IROM_Q,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  input  logic        done,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [13:0] checksum,
  output logic [6:0]  wr_count,
  output logic        run_done,
  output logic [2:0]  err
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WBUSY = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [7:0]    rom_q  [64];
  logic [7:0]    ram_q  [64];
  logic [3:0]    fifo_q [CMD_DEPTH];

  logic [2:0]    st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cv_q, cv_d;
  logic          wr_q, wr_d;
  logic [2:0]    err_q, err_d;
  logic [13:0]   sum_q, sum_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [63:0]   bm_q, bm_d;
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;

  logic          push;
  logic          empty;
  logic          full;
  logic          tout;
  logic          clr;
  logic [3:0]    head;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head  = fifo_q[rp_q[AW-1:0]];
  assign tout  = (tmr_q == TW'(TIMEOUT - 1));

  assign prog_ready = !full && (st_q == S_IDLE);
  assign push       = prog_valid && prog_ready;

  assign IROM_Q    = IROM_rd ? rom_q[IROM_A] : 8'd0;
  assign rd_data   = ram_q[rd_addr];
  assign cmd       = cmd_q;
  assign cmd_valid = cv_q;
  assign err       = err_q;
  assign checksum  = sum_q;
  assign wr_count  = cnt_q;
  assign run_done  = (st_q == S_FIN);

  always_comb begin
    st_d  = st_q;
    cmd_d = cmd_q;
    cv_d  = 1'b0;
    wr_d  = wr_q;
    err_d = err_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    bm_d  = bm_q;
    rp_d  = rp_q;
    clr   = 1'b0;
    wp_d  = wp_q + {{AW{1'b0}}, push};

    if (IRAM_valid) begin
      sum_d = sum_q + 14'(IRAM_D);
      if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
      if (bm_q[IRAM_A]) err_d[1] = 1'b1;
      bm_d[IRAM_A] = 1'b1;
    end

    unique case (st_q)
      S_IDLE: begin
        if (start) clr = 1'b1;
      end
      S_LOAD: begin
        if (!busy) begin
          st_d = S_ISSUE;
        end else if (tout) begin
          err_d[0] = 1'b1;
          st_d     = S_FIN;
        end
      end
      S_ISSUE: begin
        if (empty) begin
          err_d[2] = 1'b1;
          st_d     = S_FIN;
        end else begin
          cmd_d = head;
          cv_d  = 1'b1;
          wr_d  = (head == 4'd0);
          rp_d  = rp_q + {{AW{1'b0}}, 1'b1};
          st_d  = S_GAP;
        end
      end
      // controller only raises busy one cycle after the strobe
      S_GAP: st_d = S_WBUSY;
      S_WBUSY: begin
        if (wr_q ? done : !busy) begin
          st_d = wr_q ? S_FIN : S_ISSUE;
        end else if (tout) begin
          err_d[0] = 1'b1;
          st_d     = S_FIN;
        end
      end
      S_FIN: begin
        rp_d = wp_q;
        if (start) clr = 1'b1;
      end
      default: st_d = S_IDLE;
    endcase

    if (clr) begin
      st_d  = S_LOAD;
      bm_d  = '0;
      sum_d = '0;
      cnt_d = '0;
      err_d = '0;
    end

    tmr_d = '0;
    if (st_d == st_q && (st_q == S_LOAD || st_q == S_WBUSY))
      tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= S_IDLE;
      tmr_q <= '0;
      cmd_q <= '0;
      cv_q  <= 1'b0;
      wr_q  <= 1'b0;
      err_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      bm_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
      cmd_q <= cmd_d;
      cv_q  <= cv_d;
      wr_q  <= wr_d;
      err_q <= err_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      bm_q  <= bm_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (img_we && st_q == S_IDLE) rom_q[img_addr] <= img_data;
    if (IRAM_valid) ram_q[IRAM_A] <= IRAM_D;
    if (push) fifo_q[wp_q[AW-1:0]] <= prog_cmd;
  end

endmodule
